// File: rtl/sram_burst_controller_pkg.sv
// Shared constants and FSM encoding for the SRAM burst controller.
package sram_burst_controller_pkg;

  localparam int SRAM_ADDR_LEN = 18;
  localparam int SRAM_DATA_LEN = 32;
  localparam int ADDR_BASE_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Index width for an n-entry array, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Reloadable down-counter: tc_o marks the last cycle of each WAIT_STATES-cycle beat,
// after which the count reloads on its own while enabled.
module sram_wait_counter #(
  parameter int WAIT_STATES = 5,
  parameter int CNT_W       = $clog2(WAIT_STATES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == ONE);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = tc_o ? RELOAD : (cnt_q - ONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_burst_controller.sv
// CPU load/store port onto asynchronous SRAM: single-word stores, aligned burst loads,
// WAIT_STATES cycles per beat; ready drops combinationally on a request and pulses in DONE.
module sram_burst_controller
  import sram_burst_controller_pkg::*;
#(
  parameter int DATA_W      = SRAM_DATA_LEN,
  parameter int ADDR_W      = 32,
  parameter int SRAM_ADDR_W = SRAM_ADDR_LEN,
  parameter int ADDR_BASE   = ADDR_BASE_DEF,
  parameter int WAIT_STATES = 5,
  parameter int BURST_LEN   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_en,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             wdata,
  output logic [BURST_LEN*DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]             rd_word,
  output logic                          ready,
  inout  wire  [DATA_W-1:0]             SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0]        SRAM_ADDR,
  output logic                          SRAM_UB_N,
  output logic                          SRAM_LB_N,
  output logic                          SRAM_WE_N,
  output logic                          SRAM_CE_N,
  output logic                          SRAM_OE_N
);

  localparam int CNT_W  = $clog2(WAIT_STATES + 1);
  localparam int BCNT_W = $clog2(BURST_LEN + 1);
  localparam int BIDX_W = idx_w(BURST_LEN);
  localparam logic [SRAM_ADDR_W-1:0] ALIGN_MASK = SRAM_ADDR_W'(BURST_LEN - 1);
  localparam logic [BIDX_W-1:0]      SEL_MASK   = BIDX_W'(BURST_LEN - 1);
  localparam logic [BCNT_W-1:0]      LAST_BEAT  = BCNT_W'(BURST_LEN - 1);

  state_e                           state_q, state_d;
  logic [BCNT_W-1:0]                beat_q, beat_d;
  logic [BIDX_W-1:0]                sel_q, sel_d;
  logic [DATA_W-1:0]                wdata_q, wdata_d;
  logic [DATA_W-1:0]                rd_word_q, rd_word_d;
  logic [BURST_LEN-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0]           sram_addr_q, sram_addr_d;
  logic                             we_n_q, we_n_d, oe_n_q, oe_n_d, ce_n_q, ce_n_d;
  logic                             dq_oe_q, dq_oe_d;
  logic [SRAM_ADDR_W-1:0]           wa;
  logic [CNT_W-1:0]                 wait_cnt;
  logic                             cnt_load, cnt_en, cnt_tc, beat_end;

  assign wa       = SRAM_ADDR_W'((addr - ADDR_W'(ADDR_BASE)) >> 2);
  assign cnt_en   = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign beat_end = cnt_en && cnt_tc;

  sram_wait_counter #(
    .WAIT_STATES(WAIT_STATES),
    .CNT_W      (CNT_W)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .load_i(cnt_load),
    .en_i  (cnt_en),
    .cnt_o (wait_cnt),
    .tc_o  (cnt_tc)
  );

  // Strobe/enable values are computed for the next cycle so every SRAM pin is a flop.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rd_word_d   = rd_word_q;
    sram_addr_d = sram_addr_q;
    cnt_load    = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    ce_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          state_d     = ST_WRITE;
          cnt_load    = 1'b1;
          wdata_d     = wdata;
          sram_addr_d = wa;
          we_n_d      = 1'b0;
          ce_n_d      = 1'b0;
          dq_oe_d     = 1'b1;
        end else if (rd_en) begin
          state_d     = ST_READ;
          cnt_load    = 1'b1;
          beat_d      = '0;
          sel_d       = wa[BIDX_W-1:0] & SEL_MASK;
          sram_addr_d = wa & ~ALIGN_MASK;
          oe_n_d      = 1'b0;
          ce_n_d      = 1'b0;
        end
      end
      ST_WRITE: begin
        if (beat_end) begin
          state_d = ST_DONE;
        end else begin
          ce_n_d  = 1'b0;
          dq_oe_d = 1'b1;
          // WE_N rises one cycle early so data and address hold past the write edge.
          we_n_d  = (wait_cnt == CNT_W'(2));
        end
      end
      ST_READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        if (beat_end) begin
          rdata_d[beat_q[BIDX_W-1:0]] = SRAM_DQ;
          beat_d      = beat_q + BCNT_W'(1);
          sram_addr_d = sram_addr_q + SRAM_ADDR_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d     = ST_DONE;
            ce_n_d      = 1'b1;
            oe_n_d      = 1'b1;
            sram_addr_d = sram_addr_q;
            rd_word_d   = rdata_d[sel_q];
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rd_word_q   <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rd_word_q   <= rd_word_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      ce_n_q      <= ce_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  assign ready     = (state_q == ST_IDLE) ? ~(rd_en | wr_en) : (state_q == ST_DONE);
  assign rdata     = rdata_q;
  assign rd_word   = rd_word_q;
  assign SRAM_DQ   = dq_oe_q ? wdata_q : 'z;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // A load and store together is a pipeline bug; the store is served.
  assert property (@(posedge clk) disable iff (!rst) !(state_q == ST_IDLE && rd_en && wr_en))
    else $warning("sram_burst_controller: rd_en and wr_en both high, store served");

endmodule

// File: doc/sram_burst_controller.md
Name: sram_burst_controller

Overview:
- Parametrised successor to the single-word SRAM access path in the memory stage.
- Serves CPU load/store requests against external asynchronous SRAM with a configurable wait-state count.
- Reads fetch an aligned burst of BURST_LEN words (line fill for a future data cache); writes store a single word.
- Drives `ready`, which the pipeline uses directly as `freeze = ~ready` for IF/ID/EXE/MEM.

Parameters:
- DATA_W, 32, CPU word width; equals SRAM DQ width.
- ADDR_W, 32, CPU byte-address width.
- SRAM_ADDR_W, 18, SRAM word-address width.
- ADDR_BASE, 1024, CPU byte address that maps to SRAM word 0.
- WAIT_STATES, 5, clock cycles per SRAM beat; legal range >= 2.
- BURST_LEN, 2, words per read burst; power of two, 1..8.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rd_en  in  1  load request; level, held until ready.
- wr_en  in  1  store request; level, held until ready.
- addr  in  ADDR_W  CPU byte address.
- wdata  in  DATA_W  store data.
- rdata  out  BURST_LEN*DATA_W  burst data; beat i at [i*DATA_W +: DATA_W].
- rd_word  out  DATA_W  the beat selected by addr word offset.
- ready  out  1  high = no pending access, or access completing this cycle.
- SRAM_DQ  inout  DATA_W  SRAM data bus.
- SRAM_ADDR  out  SRAM_ADDR_W  SRAM word address.
- SRAM_UB_N, SRAM_LB_N  out  1 each  byte enables; tied 0.
- SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  out  1 each  SRAM strobes, active-low.

Behaviour:
- Address mapping: word address wa = (addr - ADDR_BASE) >> 2, truncated to SRAM_ADDR_W. No range check; wraps modulo 2^SRAM_ADDR_W.
- Read base address: wa with its low log2(BURST_LEN) bits cleared. Beat i uses base + i.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - wr_en=1 -> WRITE.
  - else rd_en=1 -> READ.
  - Write has priority when both are high; a simulation assertion flags rd_en & wr_en as illegal.
  - ready = ~(rd_en | wr_en), combinational, so the stall starts in the request cycle.
- WRITE (cycles 1..W, where W = WAIT_STATES):
  - CE_N = 0.
  - WE_N = 0 in cycles 1..W-1, then 1 in cycle W (hold time).
  - DQ driven with the wdata captured on entry; SRAM_ADDR = wa.
  - Then -> DONE.
- READ (cycles 1..W*BURST_LEN):
  - CE_N = 0, OE_N = 0, DQ = Z.
  - SRAM_ADDR = base + beat_cnt.
  - On the last wait cycle of each beat: capture DQ into rdata beat slot beat_cnt, then beat_cnt++ and wait_cnt resets.
  - After the final beat -> DONE.
- DONE:
  - ready = 1 for exactly one cycle; strobes inactive; DQ = Z.
  - Next state is IDLE unconditionally.
  - A request still held in the following cycle is treated as new; the pipeline has already advanced.
- Latency, counted from the request cycle 0:
  - write completes (ready=1) in cycle W+1;
  - read completes in cycle W*BURST_LEN+1.
- Request changes mid-access (rd_en/wr_en/addr/wdata drop or change) are ignored; the access completes using the values captured on entry.
- rdata and rd_word:
  - stable from DONE until the first beat capture of the next read;
  - writes do not alter them;
  - the rd_word select is registered on read entry.
- Strobes and SRAM_ADDR are registered outputs (no glitches). The DQ output enable is registered.
- Reset (rst=0), asynchronous, including mid-access:
  - FSM -> IDLE; counters 0;
  - WE_N = OE_N = CE_N = 1; DQ = Z;
  - SRAM_ADDR = 0; rdata = 0; rd_word = 0;
  - ready = 1, provided no request is present.
- Counters: wait_cnt is clog2(WAIT_STATES+1) bits; beat_cnt is clog2(BURST_LEN+1) bits. No overflow is reachable.

Decomposition:
- Shared constants (SRAM_ADDR_LEN, SRAM_DATA_LEN, FSM state encodings, ADDR_BASE default) go in Constants.v.
- One natural sub-module, sram_wait_counter: a load/terminal-count down-counter giving a beat-end pulse every WAIT_STATES cycles. It is instantiated once.
- Beat sequencing stays in the top FSM.

Test Plan (W=5, BURST_LEN=2, ADDR_BASE=1024 unless stated):
- Store: wr_en, addr=1032, wdata=0xDEADBEEF at cycle 0 -> ready=0 in cycles 0..5; SRAM_ADDR=2; WE_N low in cycles 1..4 and high in cycle 5; DQ=0xDEADBEEF in cycles 1..5; ready=1 only in cycle 6.
- Load: SRAM word2=0xDEADBEEF, word3=0x12345678; rd_en, addr=1036 -> SRAM_ADDR=2 in cycles 1..5 and 3 in cycles 6..10; OE_N low in cycles 1..10; ready=1 in cycle 11; rdata={0x12345678,0xDEADBEEF}; rd_word=0x12345678.
- Back-to-back: store then load, each held until ready -> ready high for exactly one cycle per access; the load is accepted the cycle after the store's DONE; there are no lost or duplicated accesses.
- Conflict: rd_en=wr_en=1, addr=1024 -> a write to word 0 is performed and the assertion fires.
- Reset: rst=0 in cycle 3 of a load -> strobes 1, DQ Z, rdata=0, ready follows the request; after release, a fresh load completes in 11 cycles.
- BURST_LEN=1: load addr=1024 -> a single beat; ready in cycle 6; rd_word=rdata.
